// File: rtl/gpio_in_capture.sv
// GPIO input capture: per-pin synchronizer, edge detection, sticky status with
// interrupt, saturating edge counter and a one-cycle register access port.
module gpio_in_capture #(
   parameter int WIDTH       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gpio_in,
   input  logic             req,
   input  logic             we,
   input  logic [4:0]       addr,
   input  logic [31:0]      wdata,
   output logic             ack,
   output logic [31:0]      rdata,
   output logic             irq
);

   typedef enum logic [2:0] {
      REG_DATA     = 3'd0,
      REG_RISE_EN  = 3'd1,
      REG_FALL_EN  = 3'd2,
      REG_STATUS   = 3'd3,
      REG_IRQ_EN   = 3'd4,
      REG_EDGE_CNT = 3'd5
   } reg_sel_t;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] status;
   logic [WIDTH-1:0] irq_en;
   logic [15:0]      edge_cnt;

   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] set_bits;
   logic             any_edge;
   logic [WIDTH-1:0] wmask;
   logic [2:0]       sel;
   logic             wr;
   logic [31:0]      rd_val;
   logic             unused_bits;

   assign data        = sync_q[SYNC_STAGES-1];
   assign sel         = addr[4:2];
   assign wr          = req & we;
   assign wmask       = wdata[WIDTH-1:0];
   assign unused_bits = ^{addr[1:0], wdata};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev <= '0;
      end else begin
         sync_q[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev <= data;
      end
   end

   assign rise     = data & ~prev;
   assign fall     = ~data & prev;
   assign set_bits = (rise & rise_en) | (fall & fall_en);
   assign any_edge = |set_bits;

   // A status bit being set in the same cycle as its W1C clear stays set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_en <= '0;
         fall_en <= '0;
         irq_en  <= '0;
         status  <= '0;
      end else begin
         if (wr && sel == REG_RISE_EN) rise_en <= wmask;
         if (wr && sel == REG_FALL_EN) fall_en <= wmask;
         if (wr && sel == REG_IRQ_EN)  irq_en  <= wmask;
         if (wr && sel == REG_STATUS)  status  <= (status & ~wmask) | set_bits;
         else                          status  <= status | set_bits;
      end
   end

   // Counts cycles with an enabled edge, not individual edges; saturates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
      end else if (wr && sel == REG_EDGE_CNT) begin
         edge_cnt <= any_edge ? 16'd1 : 16'd0;
      end else if (any_edge && edge_cnt != 16'hFFFF) begin
         edge_cnt <= edge_cnt + 16'd1;
      end
   end

   always_comb begin
      rd_val = '0;
      case (sel)
         REG_DATA:     rd_val[WIDTH-1:0] = data;
         REG_RISE_EN:  rd_val[WIDTH-1:0] = rise_en;
         REG_FALL_EN:  rd_val[WIDTH-1:0] = fall_en;
         REG_STATUS:   rd_val[WIDTH-1:0] = status;
         REG_IRQ_EN:   rd_val[WIDTH-1:0] = irq_en;
         REG_EDGE_CNT: rd_val[15:0]      = edge_cnt;
         default:      rd_val            = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack   <= 1'b0;
         rdata <= '0;
      end else begin
         ack   <= req;
         rdata <= (req && !we) ? rd_val : 32'd0;
      end
   end

   assign irq = |(status & irq_en);

endmodule

// File: tb/tb_gpio_in_capture.sv
// Randomized and directed bench for gpio_in_capture against a delay-line
// reference model of the register map.
module tb_gpio_in_capture;

   localparam int WIDTH = 32;
   localparam int SS    = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] gpio_in;
   logic        req;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;
   logic        irq;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] pins;

   // Reference model state: pin history as a pure delay line plus register map.
   logic [31:0] hist[$];
   logic [31:0] m_re, m_fe, m_st, m_ie, m_rdata;
   logic [15:0] m_cnt;
   logic        m_ack;

   gpio_in_capture #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n), .gpio_in(gpio_in), .req(req), .we(we),
      .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .irq(irq)
   );

   always #5 clk = ~clk;

   function automatic logic m_irq();
      return |(m_st & m_ie);
   endfunction

   task automatic model_reset();
      m_re = '0; m_fe = '0; m_st = '0; m_ie = '0; m_cnt = '0;
      m_ack = 1'b0; m_rdata = '0;
      hist.delete();
      for (int i = 0; i <= SS; i++) hist.push_back(32'd0);
   endtask

   // hist[0] is DATA of the previous cycle, hist[1] is DATA seen at this edge.
   task automatic model_step(input logic r, input logic w, input logic [4:0] a,
                             input logic [31:0] d, input logic [31:0] p);
      logic [31:0] dat, prv, set, rv;
      dat = hist[1];
      prv = hist[0];
      set = (dat & ~prv & m_re) | (~dat & prv & m_fe);
      case (a[4:2])
         3'd0: rv = dat;
         3'd1: rv = m_re;
         3'd2: rv = m_fe;
         3'd3: rv = m_st;
         3'd4: rv = m_ie;
         3'd5: rv = {16'd0, m_cnt};
         default: rv = 32'd0;
      endcase
      m_ack   = r;
      m_rdata = (r && !w) ? rv : 32'd0;
      if (r && w && a[4:2] == 3'd1) m_re = d;
      if (r && w && a[4:2] == 3'd2) m_fe = d;
      if (r && w && a[4:2] == 3'd4) m_ie = d;
      if (r && w && a[4:2] == 3'd3) m_st = m_st & ~d;
      m_st = m_st | set;
      if (r && w && a[4:2] == 3'd5) m_cnt = (set != 0) ? 16'd1 : 16'd0;
      else if (set != 0 && m_cnt < 16'hFFFF) m_cnt = m_cnt + 16'd1;
      hist.push_back(p);
      void'(hist.pop_front());
   endtask

   task automatic cycle(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
      req = r; we = w; addr = a; wdata = d; gpio_in = pins;
      @(posedge clk);
      model_step(r, w, a, d, pins);
      #1;
      req = 1'b0; we = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'h00, 32'd0);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      cycle(1'b1, 1'b1, a, d);
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v, output logic k);
      cycle(1'b1, 1'b0, a, 32'd0);
      v = rdata;
      k = ack;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; gpio_in = pins;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      logic k;
      pins = '0;
      do_reset();
      vectors++;
      if (ack !== 1'b0 || rdata !== 32'd0 || irq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got ack=%b rdata=%h irq=%b, expected 0/0/0", ack, rdata, irq);
      end
      for (int i = 0; i < 8; i++) begin
         rd(5'(i * 4), v, k);
         vectors++;
         if (k !== 1'b1 || v !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_reg%0d: got ack=%b rdata=%h, expected 1/00000000", i, k, v);
         end
      end
   endtask

   task automatic test_rise_irq();
      logic [31:0] v;
      logic k;
      wr(5'h04, 32'h1);
      wr(5'h10, 32'h1);
      idle(3);
      pins = 32'h1;
      cycle(1'b0, 1'b0, 5'h00, 32'd0);
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++; $display("[TB] FAIL rise_irq_edge1: got %b expected 0", irq);
      end
      rd(5'h00, v, k);
      vectors++;
      if (v !== 32'h0 || irq !== 1'b0) begin
         miscompares++; $display("[TB] FAIL rise_edge2: got data=%h irq=%b expected 0/0", v, irq);
      end
      rd(5'h00, v, k);
      vectors++;
      if (v !== 32'h1 || irq !== 1'b1) begin
         miscompares++; $display("[TB] FAIL rise_edge3: got data=%h irq=%b expected 1/1", v, irq);
      end
      rd(5'h0C, v, k);
      vectors++;
      if (v !== 32'h1) begin
         miscompares++; $display("[TB] FAIL rise_status: got %h expected 00000001", v);
      end
      rd(5'h14, v, k);
      vectors++;
      if (v !== 32'h1) begin
         miscompares++; $display("[TB] FAIL rise_edge_cnt: got %h expected 00000001", v);
      end
   endtask

   task automatic test_w1c();
      logic [31:0] v;
      logic k;
      wr(5'h0C, 32'h1);
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++; $display("[TB] FAIL w1c_irq: got %b expected 0", irq);
      end
      rd(5'h0C, v, k);
      vectors++;
      if (v !== 32'h0) begin
         miscompares++; $display("[TB] FAIL w1c_status: got %h expected 00000000", v);
      end
      pins = 32'h0;
      idle(4);
      pins = 32'h1;
      idle(4);
      wr(5'h0C, 32'h0);
      rd(5'h0C, v, k);
      vectors++;
      if (v !== 32'h1 || irq !== 1'b1) begin
         miscompares++; $display("[TB] FAIL w1c_zero_write: got status=%h irq=%b expected 00000001/1", v, irq);
      end
   endtask

   task automatic test_fall_all();
      logic [31:0] v;
      logic k;
      wr(5'h04, 32'h0);
      wr(5'h08, 32'hFFFF_FFFF);
      pins = 32'hFFFF_FFFF;
      idle(4);
      wr(5'h0C, 32'hFFFF_FFFF);
      wr(5'h14, 32'h0);
      pins = 32'h0;
      idle(5);
      rd(5'h0C, v, k);
      vectors++;
      if (v !== 32'hFFFF_FFFF) begin
         miscompares++; $display("[TB] FAIL fall_status: got %h expected ffffffff", v);
      end
      rd(5'h14, v, k);
      vectors++;
      if (v !== 32'h1) begin
         miscompares++; $display("[TB] FAIL fall_edge_cnt: got %h expected 00000001", v);
      end
   endtask

   task automatic test_same_cycle();
      logic [31:0] v;
      logic k;
      wr(5'h08, 32'h0);
      wr(5'h04, 32'h8);
      idle(4);
      wr(5'h0C, 32'hFFFF_FFFF);
      pins = 32'h8;
      idle(2);
      wr(5'h0C, 32'h8);
      rd(5'h0C, v, k);
      vectors++;
      if (v !== 32'h8) begin
         miscompares++; $display("[TB] FAIL set_beats_clear: got %h expected 00000008", v);
      end
   endtask

   task automatic test_saturate();
      logic [31:0] v;
      logic k;
      wr(5'h04, 32'h1);
      wr(5'h08, 32'h1);
      pins = 32'h0;
      idle(4);
      wr(5'h14, 32'h0);
      for (int i = 0; i < 70000; i++) begin
         pins[0] = ~pins[0];
         idle(1);
      end
      idle(4);
      rd(5'h14, v, k);
      vectors++;
      if (v !== 32'h0000_FFFF) begin
         miscompares++; $display("[TB] FAIL cnt_saturate: got %h expected 0000ffff", v);
      end
      wr(5'h14, 32'h1234);
      rd(5'h14, v, k);
      vectors++;
      if (v !== 32'h0) begin
         miscompares++; $display("[TB] FAIL cnt_clear: got %h expected 00000000", v);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      logic k;
      wr(5'h10, 32'h5A);
      rd(5'h10, v, k);
      vectors++;
      if (k !== 1'b1 || v !== 32'h5A) begin
         miscompares++; $display("[TB] FAIL wr_then_rd: got ack=%b rdata=%h expected 1/0000005a", k, v);
      end
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, i[0], 5'(i * 4), 32'h0);
         vectors++;
         if (ack !== 1'b1 || rdata !== m_rdata) begin
            miscompares++;
            $display("[TB] FAIL b2b_%0d: got ack=%b rdata=%h expected 1/%h", i, ack, rdata, m_rdata);
         end
      end
      idle(1);
      vectors++;
      if (ack !== 1'b0 || rdata !== 32'd0) begin
         miscompares++; $display("[TB] FAIL b2b_idle: got ack=%b rdata=%h expected 0/0", ack, rdata);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      logic k;
      wr(5'h04, 32'h1);
      wr(5'h10, 32'h1);
      pins = 32'h0;
      idle(4);
      pins = 32'h1;
      idle(4);
      req = 1'b1; we = 1'b0; addr = 5'h0C;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (ack !== 1'b0 || irq !== 1'b0 || rdata !== 32'd0) begin
         miscompares++; $display("[TB] FAIL mid_reset_outputs: got ack=%b irq=%b rdata=%h expected 0/0/0", ack, irq, rdata);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      vectors++;
      if (ack !== 1'b0) begin
         miscompares++; $display("[TB] FAIL dropped_ack: got %b expected 0", ack);
      end
      idle(5);
      for (int i = 1; i < 6; i++) begin
         rd(5'(i * 4), v, k);
         vectors++;
         if (v !== 32'd0) begin
            miscompares++; $display("[TB] FAIL post_reset_reg%0d: got %h expected 00000000", i, v);
         end
      end
      vectors++;
      if (irq !== 1'b0) begin
         miscompares++; $display("[TB] FAIL post_reset_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_random();
      logic [4:0]  a;
      logic [31:0] d;
      logic        r, w;
      wr(5'h04, $urandom);
      wr(5'h08, $urandom);
      wr(5'h10, $urandom);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) pins = $urandom;
         r = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 2) == 0);
         a = {3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         d = $urandom;
         cycle(r, w, a, d);
         vectors++;
         if (ack !== m_ack || rdata !== m_rdata || irq !== m_irq()) begin
            miscompares++;
            $display("[TB] FAIL random_%0d: got ack=%b rdata=%h irq=%b expected %b/%h/%b",
                     i, ack, rdata, irq, m_ack, m_rdata, m_irq());
         end
      end
   endtask

   initial begin
      pins = '0;
      test_reset();
      test_rise_irq();
      test_w1c();
      test_fall_all();
      test_same_cycle();
      test_back_to_back();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
